// File: rtl/sar_search_pkg.sv
// sar_search_pkg
// Shared definitions for the successive-approximation search block:
//   state_e       - FSM states (IDLE / PROBE / DONE)
//   SAR_DEFAULT_W - default probe/result width in bits
package sar_search_pkg;

  localparam int SAR_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search.sv
// sar_search
// Finds a hidden two's-complement target by bit-serial successive
// approximation. Each PROBE cycle it offers a trial value to an external
// comparator and refines one bit of the answer from the reply.
//
// Ports
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   start           - begin a search; only looked at while idle
//   probe  [W-1:0]  - signed trial value driven as A to the comparator
//   cmp_eq, cmp_gt  - comparator reply for probe vs. target (same cycle)
//   cas_eq, cas_gt  - cascade seeds for the comparator (1 / 0)
//   busy            - high while probing
//   done            - one-cycle pulse after the last comparison
//   result [W-1:0]  - found target, held until overwritten by the next search
//   steps           - comparisons used by the most recent search
module sar_search
  import sar_search_pkg::*;
#(
  parameter int W = SAR_DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [W-1:0]         probe,
  input  logic                 cmp_eq,
  input  logic                 cmp_gt,
  output logic                 cas_eq,
  output logic                 cas_gt,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         result,
  output logic [$clog2(W):0]   steps
);

  localparam int IW = $clog2(W);
  localparam int SW = IW + 1;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic [SW-1:0]   steps_q, steps_d;

  logic [W-1:0]    bit_mask;
  logic [W-1:0]    sign_mask;
  logic [W-1:0]    acc_next;
  logic [W-1:0]    probe_w;

  // The accumulator works in offset binary so that plain bit-by-bit
  // refinement walks the signed range in order; flipping the top bit
  // converts between offset binary and two's complement.
  always_comb begin
    bit_mask  = {{(W-1){1'b0}}, 1'b1} << idx_q;
    sign_mask = {1'b1, {(W-1){1'b0}}};
    acc_next  = cmp_gt ? acc_q : (acc_q | bit_mask);
    probe_w   = (state_q == ST_PROBE) ? ((acc_q | bit_mask) ^ sign_mask) : '0;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    steps_d  = steps_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = IW'(W - 1);
          steps_d = '0;
          state_d = ST_PROBE;
        end
      end
      ST_PROBE: begin
        steps_d = steps_q + SW'(1);
        // An exact match ends the search early and wins over cmp_gt.
        if (cmp_eq) begin
          result_d = probe_w;
          state_d  = ST_DONE;
        end else begin
          acc_d = acc_next;
          if (idx_q == '0) begin
            result_d = acc_next ^ sign_mask;
            state_d  = ST_DONE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= IW'(W - 1);
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

  assign probe  = probe_w;
  assign busy   = (state_q == ST_PROBE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign steps  = steps_q;
  assign cas_eq = 1'b1;
  assign cas_gt = 1'b0;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search
// Self-checking bench for sar_search (W=8). A behavioural comparator plays
// the target oracle. For each search the bench predicts, cycle by cycle,
// what busy/done/probe must show, derived from the target by arithmetic on
// the offset-binary value, and a single compare process checks the DUT
// against that expectation queue on every falling edge.
module tb_sar_search;

  localparam int W = 8;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] probe;
    logic [7:0] result;
    logic [3:0] steps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] probe;
  logic       cmp_eq, cmp_gt;
  logic       cas_eq, cas_gt;
  logic       busy, done;
  logic [7:0] result;
  logic [3:0] steps;

  logic [7:0] target_r = 8'h00;
  logic       force_both = 1'b0;
  logic       check_en = 1'b0;

  int tests = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  exp_t       cur_e;
  logic [7:0] last_result = 8'h00;
  logic [3:0] last_steps = 4'd0;

  sar_search #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .probe  (probe),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cas_eq (cas_eq),
    .cas_gt (cas_gt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps)
  );

  // Two's-complement comparator, A = probe, B = target, seeded by the
  // cascade inputs. force_both makes it illegally raise gt on equality.
  assign cmp_eq = cas_eq & (probe == target_r);
  assign cmp_gt = ($signed(probe) > $signed(target_r))
                | ((probe == target_r) & cas_gt)
                | (force_both & (probe == target_r));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Predict the probe sequence for target t: with u = t + 128, the probe
  // at bit i keeps u's bits above i, sets bit i, clears the rest.
  task automatic pushSearch(input logic [7:0] t, output int n);
    int   ts;
    int   u;
    int   p;
    exp_t e;
    ts = $signed(t);
    u  = ts + 128;
    n  = 0;
    for (int i = 7; i >= 0; i--) begin
      p = (u / (2 ** (i + 1))) * (2 ** (i + 1)) + (2 ** i) - 128;
      e = '{busy: 1'b1, done: 1'b0, probe: 8'(p), result: 8'h00, steps: 4'd0};
      exp_q.push_back(e);
      n++;
      if (p == ts) break;
    end
    e = '{busy: 1'b0, done: 1'b1, probe: 8'h00, result: t, steps: 4'(n)};
    exp_q.push_back(e);
  endtask

  task automatic pushIdle();
    exp_t e;
    e = '{busy: 1'b0, done: 1'b0, probe: 8'h00, result: 8'h00, steps: 4'd0};
    exp_q.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int cnt = 0;
    while (exp_q.size() > 0 && cnt < budget) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] t);
    int n;
    @(posedge clk);
    #1;
    obs_q.delete();
    target_r = t;
    start    = 1'b1;
    pushIdle();
    pushSearch(t, n);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain(30);
    #1;
  endtask

  // start stays high through both searches; the second one must only
  // launch from IDLE after the first DONE.
  task automatic runBackToBack(input logic [7:0] t1, input logic [7:0] t2);
    int n1, n2;
    @(posedge clk);
    #1;
    target_r = t1;
    start    = 1'b1;
    pushIdle();
    pushSearch(t1, n1);
    pushIdle();
    pushSearch(t2, n2);
    for (int c = 1; c <= n1 + n2 + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == n1 + 1) target_r = t2;
      if (c == n1 + n2 + 3) start = 1'b0;
    end
    waitDrain(30);
    #1;
  endtask

  task automatic checkSeq(input string name, input logic [7:0] lit[8]);
    checkOutput({name, "_len"}, obs_q.size(), 8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++)
      checkOutput(name, obs_q[k], lit[k]);
  endtask

  // Single compare process: every falling edge, pop one expected cycle, or
  // when nothing is pending expect a quiet idle block holding its result.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      if (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        checkOutput("busy", busy, cur_e.busy);
        checkOutput("done", done, cur_e.done);
        checkOutput("probe", probe, cur_e.probe);
        if (cur_e.busy) obs_q.push_back(probe);
        if (cur_e.done) begin
          checkOutput("result", result, cur_e.result);
          checkOutput("steps", steps, cur_e.steps);
          last_result = cur_e.result;
          last_steps  = cur_e.steps;
        end
      end else begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_probe", probe, 0);
        checkOutput("held_result", result, last_result);
        checkOutput("held_steps", steps, last_steps);
        checkOutput("cas_seeds", {cas_eq, cas_gt}, 2'b10);
      end
    end
  end

  initial begin
    logic [7:0] seq[8];
    logic [7:0] t;

    // Reset state.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_probe", probe, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_steps", steps, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Target zero: exact match on the very first probe.
    applyStimulus(8'h00);
    checkOutput("t00_nprobes", obs_q.size(), 1);
    checkOutput("t00_steps", steps, 1);
    checkOutput("t00_result", result, 8'h00);

    // Most negative target: every reply is gt.
    applyStimulus(8'h80);
    seq = '{8'h00, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
    checkSeq("t80_seq", seq);
    checkOutput("t80_result", result, 8'h80);
    checkOutput("t80_steps", steps, 8);

    // Most positive target: equality only on the last step.
    applyStimulus(8'h7F);
    seq = '{8'h00, 8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F};
    checkSeq("t7F_seq", seq);
    checkOutput("t7F_result", result, 8'h7F);
    checkOutput("t7F_steps", steps, 8);

    applyStimulus(8'h2E);
    checkOutput("t2E_result", result, 8'h2E);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t2E_stable", result, 8'h2E);

    // Reset in the middle of a search (during step 4).
    check_en = 1'b0;
    @(posedge clk);
    #1;
    target_r = 8'h55;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_probe", probe, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_steps", steps, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    last_result = 8'h00;
    last_steps  = 4'd0;
    check_en    = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(8'hD3);
    checkOutput("tD3_result", result, 8'hD3);

    // start held high through PROBE/DONE.
    runBackToBack(8'h01, 8'hFF);
    checkOutput("b2b_result", result, 8'hFF);

    // Random targets, a few with the illegal eq+gt reply to exercise priority.
    for (int k = 0; k < 24; k++) begin
      t = 8'($urandom_range(0, 255));
      force_both = (k % 4 == 3);
      applyStimulus(t);
    end
    force_both = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
